// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: steps a small combinational circuit through every input
// combination, samples its outputs, and scores them against a packed expected table.
module truth_table_sweeper #(
   parameter int N_IN   = 4,
   parameter int N_OUT  = 3,
   parameter int SETTLE = 1,
   parameter logic [N_OUT*(1<<N_IN)-1:0] EXP_MASK = 48'hAC8C_E0E6_2202
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic [N_IN-1:0]  dut_in,
   input  logic [N_OUT-1:0] dut_out,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [N_IN:0]    err_count,
   output logic [N_IN-1:0]  first_fail_idx,
   output logic             first_fail_valid,
   output logic [N_OUT-1:0] fail_bits,
   output logic [1:0]       fsm_state
);

   // Handshake: start is sampled only in IDLE; busy covers DRIVE/SAMPLE and
   // done is a single-cycle pulse, during which all results are already valid.

   localparam int DEPTH = 1 << N_IN;
   localparam int CW    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CW-1:0]   SETTLE_LOAD = CW'(SETTLE - 1);
   localparam logic [N_IN-1:0] LAST_IDX    = N_IN'(DEPTH - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DRIVE  = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [N_IN-1:0]  idx;
   logic [CW-1:0]    settle_cnt;
   logic [N_OUT-1:0] exp_vec;
   logic [N_OUT-1:0] mis;
   logic             last_vec;

   assign dut_in    = idx;
   assign fsm_state = state;
   assign last_vec  = (idx == LAST_IDX);
   assign mis       = dut_out ^ exp_vec;

   // Column j of the table is output j; row idx is the current vector.
   always_comb begin
      exp_vec = '0;
      for (int j = 0; j < N_OUT; j++) begin
         exp_vec[j] = EXP_MASK[j*DEPTH + int'(idx)];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = DRIVE;
            end
         end
         DRIVE: begin
            busy = 1'b1;
            if (settle_cnt == '0) begin
               state_nxt = SAMPLE;
            end
         end
         SAMPLE: begin
            busy      = 1'b1;
            state_nxt = last_vec ? DONE : DRIVE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx              <= '0;
         settle_cnt       <= '0;
         err_count        <= '0;
         pass             <= 1'b0;
         first_fail_idx   <= '0;
         first_fail_valid <= 1'b0;
         fail_bits        <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  idx              <= '0;
                  settle_cnt       <= SETTLE_LOAD;
                  err_count        <= '0;
                  pass             <= 1'b0;
                  first_fail_idx   <= '0;
                  first_fail_valid <= 1'b0;
                  fail_bits        <= '0;
               end
            end
            DRIVE: begin
               if (settle_cnt != '0) begin
                  settle_cnt <= settle_cnt - CW'(1);
               end
            end
            SAMPLE: begin
               if (mis != '0) begin
                  err_count <= err_count + (N_IN+1)'(1);
                  fail_bits <= fail_bits | mis;
                  if (!first_fail_valid) begin
                     first_fail_idx   <= idx;
                     first_fail_valid <= 1'b1;
                  end
               end
               // pass is resolved here so it is already valid during the done pulse.
               if (last_vec) begin
                  pass <= (err_count == '0) && (mis == '0);
               end else begin
                  idx        <= idx + N_IN'(1);
                  settle_cnt <= SETTLE_LOAD;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: golden circuits modelled from their
// boolean equations, one task per scenario, one summary line at the end.
module tb_truth_table_sweeper;

   logic       clk;
   logic       rst_n;
   logic       start, start3;
   logic [3:0] dut_in, dut_in3;
   logic [2:0] dut_out, dut_out3;
   logic       busy, busy3, done, done3, pass, pass3;
   logic [4:0] err_count, err_count3;
   logic [3:0] first_fail_idx, first_fail_idx3;
   logic       first_fail_valid, first_fail_valid3;
   logic [2:0] fail_bits, fail_bits3;
   logic [1:0] fsm_state, fsm_state3;
   logic [2:0] kill;

   int n_cmp = 0;
   int n_err = 0;

   function automatic logic [2:0] golden(input logic [3:0] v);
      logic a, b, c, d;
      logic [2:0] o;
      a = v[3]; b = v[2]; c = v[1]; d = v[0];
      o[0] = (a | ~b) & ~c & (c | d);
      o[1] = ((~c & d) | (b & c & d) | (c & ~d)) & (~a | b);
      o[2] = (((a & b) | c) & d) | (~b & c);
      return o;
   endfunction

   assign dut_out  = golden(dut_in) & ~kill;
   assign dut_out3 = golden(dut_in3);

   truth_table_sweeper #(.SETTLE(1)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .dut_in(dut_in), .dut_out(dut_out),
      .busy(busy), .done(done), .pass(pass), .err_count(err_count),
      .first_fail_idx(first_fail_idx), .first_fail_valid(first_fail_valid),
      .fail_bits(fail_bits), .fsm_state(fsm_state)
   );

   truth_table_sweeper #(.SETTLE(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .start(start3), .dut_in(dut_in3), .dut_out(dut_out3),
      .busy(busy3), .done(done3), .pass(pass3), .err_count(err_count3),
      .first_fail_idx(first_fail_idx3), .first_fail_valid(first_fail_valid3),
      .fail_bits(fail_bits3), .fsm_state(fsm_state3)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; start3 = 1'b0; kill = 3'b000;
      repeat (2) @(negedge clk);
      n_cmp++; if (dut_in !== 4'd0) begin n_err++; $display("FAIL reset_dut_in: got %0h want 0", dut_in); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
      n_cmp++; if (pass !== 1'b0) begin n_err++; $display("FAIL reset_pass: got %b want 0", pass); end
      n_cmp++; if (err_count !== 5'd0) begin n_err++; $display("FAIL reset_err_count: got %0d want 0", err_count); end
      n_cmp++; if (first_fail_valid !== 1'b0) begin n_err++; $display("FAIL reset_ffv: got %b want 0", first_fail_valid); end
      n_cmp++; if (fail_bits !== 3'b000) begin n_err++; $display("FAIL reset_fail_bits: got %b want 000", fail_bits); end
      n_cmp++; if (fsm_state !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", fsm_state); end
      n_cmp++; if (dut_in3 !== 4'd0 || busy3 !== 1'b0) begin n_err++; $display("FAIL reset_dut3: dut_in %0h busy %b want 0 0", dut_in3, busy3); end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy: got %b want 0", busy); end
   endtask

   // Golden circuits, SETTLE=1: each vector held 2 cycles, done in cycle 32 after E0.
   task automatic test_golden_sweep();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c <= 33; c++) begin
         if (c < 32) begin
            n_cmp++; if (dut_in !== 4'(c / 2)) begin n_err++; $display("FAIL golden_dut_in c=%0d: got %0d want %0d", c, dut_in, c / 2); end
         end
         n_cmp++; if (busy !== (c < 32)) begin n_err++; $display("FAIL golden_busy c=%0d: got %b want %b", c, busy, c < 32); end
         n_cmp++; if (done !== (c == 32)) begin n_err++; $display("FAIL golden_done c=%0d: got %b want %b", c, done, c == 32); end
         if (c >= 32) begin
            n_cmp++; if (pass !== 1'b1) begin n_err++; $display("FAIL golden_pass c=%0d: got %b want 1", c, pass); end
            n_cmp++; if (err_count !== 5'd0) begin n_err++; $display("FAIL golden_err_count c=%0d: got %0d want 0", c, err_count); end
            n_cmp++; if (fail_bits !== 3'b000) begin n_err++; $display("FAIL golden_fail_bits c=%0d: got %b want 000", c, fail_bits); end
            n_cmp++; if (first_fail_valid !== 1'b0) begin n_err++; $display("FAIL golden_ffv c=%0d: got %b want 0", c, first_fail_valid); end
         end
         @(negedge clk);
      end
   endtask

   // start held high: one done per sweep, restart one cycle after returning to IDLE.
   task automatic test_held_start();
      int n_done;
      logic exp_busy;
      n_done = 0;
      start = 1'b1;
      @(negedge clk);
      for (int c = 0; c <= 67; c++) begin
         exp_busy = (c < 32) || (c >= 34 && c < 66);
         if (done === 1'b1) n_done++;
         n_cmp++; if (done !== (c == 32 || c == 66)) begin n_err++; $display("FAIL held_done c=%0d: got %b", c, done); end
         n_cmp++; if (busy !== exp_busy) begin n_err++; $display("FAIL held_busy c=%0d: got %b want %b", c, busy, exp_busy); end
         if (c == 0 || c == 34) begin
            n_cmp++; if (pass !== 1'b0) begin n_err++; $display("FAIL held_pass_cleared c=%0d: got %b want 0", c, pass); end
         end
         if (c == 33 || c == 67) begin
            n_cmp++; if (pass !== 1'b1) begin n_err++; $display("FAIL held_pass_hold c=%0d: got %b want 1", c, pass); end
         end
         if (c == 67) start = 1'b0;
         @(negedge clk);
      end
      n_cmp++; if (n_done !== 2) begin n_err++; $display("FAIL held_done_count: got %0d want 2", n_done); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL held_stop_busy: got %b want 0", busy); end
   endtask

   // Output 2 (dut_out[1]) stuck at 0; expected results derived from the model.
   task automatic test_stuck_output();
      int exp_err;
      int exp_first;
      logic [2:0] exp_bits;
      logic [2:0] m;
      kill = 3'b010;
      exp_err = 0; exp_first = -1; exp_bits = 3'b000;
      for (int i = 0; i < 16; i++) begin
         m = golden(4'(i)) ^ (golden(4'(i)) & ~kill);
         if (m != 3'b000) begin
            exp_err++;
            exp_bits |= m;
            if (exp_first < 0) exp_first = i;
         end
      end
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 32; c++) @(negedge clk);
      n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL stuck_done: got %b want 1", done); end
      n_cmp++; if (err_count !== 5'(exp_err) || err_count !== 5'd8) begin n_err++; $display("FAIL stuck_err_count: got %0d want %0d", err_count, exp_err); end
      n_cmp++; if (first_fail_idx !== 4'(exp_first) || first_fail_idx !== 4'd1) begin n_err++; $display("FAIL stuck_first_idx: got %0d want %0d", first_fail_idx, exp_first); end
      n_cmp++; if (first_fail_valid !== 1'b1) begin n_err++; $display("FAIL stuck_ffv: got %b want 1", first_fail_valid); end
      n_cmp++; if (fail_bits !== exp_bits || fail_bits !== 3'b010) begin n_err++; $display("FAIL stuck_fail_bits: got %b want %b", fail_bits, exp_bits); end
      n_cmp++; if (pass !== 1'b0) begin n_err++; $display("FAIL stuck_pass: got %b want 0", pass); end
      repeat (3) @(negedge clk);
      n_cmp++; if (err_count !== 5'd8 || busy !== 1'b0) begin n_err++; $display("FAIL stuck_hold: err %0d busy %b want 8 0", err_count, busy); end
      kill = 3'b000;
   endtask

   // Async reset while dut_in=7, then no resume without a new start.
   task automatic test_reset_mid_sweep();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 14; c++) @(negedge clk);
      n_cmp++; if (dut_in !== 4'd7 || busy !== 1'b1) begin n_err++; $display("FAIL mid_pre: dut_in %0d busy %b want 7 1", dut_in, busy); end
      #1 rst_n = 1'b0;
      #1;
      n_cmp++; if (dut_in !== 4'd0) begin n_err++; $display("FAIL mid_dut_in: got %0d want 0", dut_in); end
      n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0) begin n_err++; $display("FAIL mid_flags: busy %b done %b pass %b want 0 0 0", busy, done, pass); end
      n_cmp++; if (err_count !== 5'd0 || first_fail_valid !== 1'b0 || fail_bits !== 3'b000) begin n_err++; $display("FAIL mid_results: err %0d ffv %b bits %b want 0", err_count, first_fail_valid, fail_bits); end
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         n_cmp++; if (busy !== 1'b0 || dut_in !== 4'd0) begin n_err++; $display("FAIL mid_no_resume c=%0d: busy %b dut_in %0d want 0 0", c, busy, dut_in); end
      end
   endtask

   // SETTLE=3: each vector held 4 cycles, done in cycle 64 after E0.
   task automatic test_settle3();
      start3 = 1'b1;
      @(negedge clk);
      start3 = 1'b0;
      for (int c = 0; c <= 65; c++) begin
         if (c < 64) begin
            n_cmp++; if (dut_in3 !== 4'(c / 4)) begin n_err++; $display("FAIL s3_dut_in c=%0d: got %0d want %0d", c, dut_in3, c / 4); end
         end
         n_cmp++; if (done3 !== (c == 64)) begin n_err++; $display("FAIL s3_done c=%0d: got %b want %b", c, done3, c == 64); end
         n_cmp++; if (busy3 !== (c < 64)) begin n_err++; $display("FAIL s3_busy c=%0d: got %b want %b", c, busy3, c < 64); end
         @(negedge clk);
      end
      n_cmp++; if (pass3 !== 1'b1 || err_count3 !== 5'd0) begin n_err++; $display("FAIL s3_result: pass %b err %0d want 1 0", pass3, err_count3); end
      n_cmp++; if (first_fail_valid3 !== 1'b0 || fail_bits3 !== 3'b000 || first_fail_idx3 !== 4'd0) begin n_err++; $display("FAIL s3_fail_info: ffv %b bits %b idx %0d want 0", first_fail_valid3, fail_bits3, first_fail_idx3); end
      n_cmp++; if (fsm_state3 !== 2'd0) begin n_err++; $display("FAIL s3_state: got %0d want 0", fsm_state3); end
   endtask

   initial begin
      test_reset();
      test_golden_sweep();
      test_held_start();
      test_stuck_output();
      test_reset_mid_sweep();
      test_settle3();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
